// File: rtl/cpu_pkg.sv
// Shared encodings and helpers for the program-counter sequencer.
// Defines branch-select/pc-select codes and the sequencer FSM state type.
package cpu_pkg;

    localparam logic [1:0] BS_SEQ    = 2'b00;
    localparam logic [1:0] BS_COND   = 2'b01;
    localparam logic [1:0] BS_JREG   = 2'b10;
    localparam logic [1:0] BS_UNCOND = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_BRA  = 2'b01;
    localparam logic [1:0] SEL_BUSA = 2'b10;
    localparam logic [1:0] SEL_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_FLUSH  = 2'b10
    } pc_state_e;

    // A conditional branch is taken when the zero flag differs from ps.
    function automatic logic cond_taken(input logic zero, input logic ps);
        return zero ^ ps;
    endfunction

endpackage

// File: rtl/pc_flush_timer.sv
// Loadable down-counter that holds flush high for FLUSH_CYCLES cycles.
// Ports: clk, rst_n (sync, active-low), load in; flush (busy), done (last cycle) out.
import cpu_pkg::*;

module pc_flush_timer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic flush,
    output logic done
);

    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= 3'(FLUSH_CYCLES);
        end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign flush = (cnt != 3'd0);
    assign done  = (cnt == 3'd1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, resolves next-address selection,
// handshakes with instruction memory and flushes the pipeline on taken transfers.
// Ports: clk, rst_n (sync, active-low), imem_ready, ctrl_valid, bs, ps, zero,
// bra_target, bus_a, stall in; imem_req, ctrl_ready, pc, pc_sel, flush,
// taken_count out. Optional macro PC_SEQ_TAKEN_CNT_EN enables taken_count.
import cpu_pkg::*;

module pc_sequencer #(
    parameter int               PC_W         = 32,
    parameter logic [PC_W-1:0]  RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            imem_ready,
    input  logic            ctrl_valid,
    input  logic [1:0]      bs,
    input  logic            ps,
    input  logic            zero,
    input  logic [PC_W-1:0] bra_target,
    input  logic [PC_W-1:0] bus_a,
    input  logic            stall,
    output logic            imem_req,
    output logic            ctrl_ready,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      pc_sel,
    output logic            flush,
    output logic [15:0]     taken_count
);

    pc_state_e       state;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] nxt_pc;
    logic [1:0]      nxt_sel;
    logic            nxt_taken;
    logic            xfer;
    logic            flush_done;

    assign imem_req   = (state == ST_FETCH);
    assign ctrl_ready = (state == ST_DECODE) & ctrl_valid & ~stall;
    assign xfer       = ctrl_ready & nxt_taken;

    always_comb begin
        pc_inc    = pc + {{(PC_W-1){1'b0}}, 1'b1};
        nxt_pc    = pc_inc;
        nxt_sel   = SEL_SEQ;
        nxt_taken = 1'b0;
        unique case (bs)
            BS_SEQ: begin
                nxt_pc = pc_inc;
            end
            BS_COND: begin
                if (cond_taken(zero, ps)) begin
                    nxt_pc    = bra_target;
                    nxt_sel   = SEL_BRA;
                    nxt_taken = 1'b1;
                end
            end
            BS_JREG: begin
                nxt_pc    = bus_a;
                nxt_sel   = SEL_BUSA;
                nxt_taken = 1'b1;
            end
            BS_UNCOND: begin
                nxt_pc    = bra_target;
                nxt_sel   = SEL_BRA;
                nxt_taken = 1'b1;
            end
            default: begin
                nxt_pc = pc_inc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            pc_sel <= SEL_HOLD;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    pc_sel <= SEL_HOLD;
                    if (imem_ready) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (ctrl_ready) begin
                        pc     <= nxt_pc;
                        pc_sel <= nxt_sel;
                        state  <= nxt_taken ? ST_FLUSH : ST_FETCH;
                    end else begin
                        pc_sel <= SEL_HOLD;
                    end
                end
                ST_FLUSH: begin
                    // pc_sel keeps the applied selection while the flush drains.
                    if (flush_done || !flush) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    pc_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (xfer),
        .flush(flush),
        .done (flush_done)
    );

`ifdef PC_SEQ_TAKEN_CNT_EN
    logic [15:0] taken_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q <= 16'h0000;
        end else if (xfer && (taken_q != 16'hFFFF)) begin
            taken_q <= taken_q + 16'h0001;
        end
    end

    assign taken_count = taken_q;
`else
    assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a decision scoreboard.
// Covers reset, sequential/branch/jump decisions, wrap, stall, reset-in-flush, counter.
import cpu_pkg::*;

module tb_pc_sequencer;

    localparam int          PC_W = 32;
    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam int          FC   = 2;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        tk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        ctrl_valid;
    logic [1:0]  bs;
    logic        ps;
    logic        zero;
    logic [31:0] bra_target;
    logic [31:0] bus_a;
    logic        stall;
    logic        imem_req;
    logic        ctrl_ready;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic        flush;
    logic [15:0] taken_count;

    exp_t        sbq[$];
    logic [31:0] model_pc;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W(PC_W),
        .RESET_PC(RPC),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_ready(imem_ready),
        .ctrl_valid(ctrl_valid),
        .bs(bs),
        .ps(ps),
        .zero(zero),
        .bra_target(bra_target),
        .bus_a(bus_a),
        .stall(stall),
        .imem_req(imem_req),
        .ctrl_ready(ctrl_ready),
        .pc(pc),
        .pc_sel(pc_sel),
        .flush(flush),
        .taken_count(taken_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_decode();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait imem_req=%b want 1", imem_req);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL decode_req imem_req=%b want 0", imem_req);
        end
    endtask

    task automatic decide(input logic [1:0] b, input logic p,
                          input logic z, input logic [31:0] tgt,
                          input logic [31:0] ba);
        exp_t e;
        to_decode();
        ctrl_valid = 1'b1;
        bs = b;
        ps = p;
        zero = z;
        bra_target = tgt;
        bus_a = ba;
        #1;
        checks++;
        if (ctrl_ready !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_ready got=%b want 1", ctrl_ready);
        end
        e.tk = 1'b1;
        case (b)
            2'b00: begin e.pc = model_pc + 32'd1; e.sel = 2'b11; e.tk = 1'b0; end
            2'b01: begin
                if ((z ^ p) == 1'b1) begin
                    e.pc = tgt; e.sel = 2'b01;
                end else begin
                    e.pc = model_pc + 32'd1; e.sel = 2'b11; e.tk = 1'b0;
                end
            end
            2'b10: begin e.pc = ba; e.sel = 2'b10; end
            default: begin e.pc = tgt; e.sel = 2'b01; end
        endcase
        model_pc = e.pc;
        sbq.push_back(e);
        tick();
        ctrl_valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (pc !== e.pc || pc_sel !== e.sel) begin
            errors++;
            $display("FAIL decide bs=%b pc=%h sel=%b want pc=%h sel=%b",
                     b, pc, pc_sel, e.pc, e.sel);
        end
        if (e.tk) begin
            for (int i = 0; i < FC; i++) begin
                checks++;
                if (flush !== 1'b1 || imem_req !== 1'b0 || pc !== e.pc) begin
                    errors++;
                    $display("FAIL flush_cyc%0d flush=%b req=%b pc=%h want 1 0 %h",
                             i, flush, imem_req, pc, e.pc);
                end
                tick();
            end
        end
        checks++;
        if (flush !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL post_decide flush=%b req=%b want 0 1", flush, imem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ctrl_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== RPC || imem_req !== 1'b1 || flush !== 1'b0 ||
            pc_sel !== 2'b00 || taken_count !== 16'h0) begin
            errors++;
            $display("FAIL reset pc=%h req=%b flush=%b sel=%b cnt=%h want %h 1 0 00 0",
                     pc, imem_req, flush, pc_sel, taken_count, RPC);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ctrl_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ignore ctrl_ready=%b want 0", ctrl_ready);
        end
        ctrl_valid = 1'b0;
        model_pc = RPC;
    endtask

    task automatic test_seq();
        decide(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_cond();
        decide(2'b01, 1'b0, 1'b1, 32'h0000_2000, 32'h0);
        decide(2'b01, 1'b0, 1'b0, 32'h0000_3000, 32'h0);
        decide(2'b01, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        decide(2'b01, 1'b1, 1'b1, 32'h0000_0700, 32'h0);
    endtask

    task automatic test_wrap();
        decide(2'b10, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        decide(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (pc !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap pc=%h want 00000000", pc);
        end
    endtask

    task automatic test_stall_reset();
        logic [31:0] held;
        to_decode();
        held = pc;
        stall = 1'b1;
        ctrl_valid = 1'b1;
        bs = 2'b10;
        bus_a = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl_ready !== 1'b0 || pc !== held || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d rdy=%b pc=%h req=%b want 0 %h 0",
                         i, ctrl_ready, pc, imem_req, held);
            end
            tick();
        end
        checks++;
        if (pc_sel !== 2'b00) begin
            errors++;
            $display("FAIL stall_sel sel=%b want 00", pc_sel);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (ctrl_ready !== 1'b1) begin
            errors++;
            $display("FAIL unstall ctrl_ready=%b want 1", ctrl_ready);
        end
        tick();
        ctrl_valid = 1'b0;
        checks++;
        if (pc !== 32'h40 || pc_sel !== 2'b10 || flush !== 1'b1) begin
            errors++;
            $display("FAIL stall_jump pc=%h sel=%b flush=%b want 40 10 1",
                     pc, pc_sel, flush);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (pc !== RPC || flush !== 1'b0 || pc_sel !== 2'b00 ||
            imem_req !== 1'b1 || taken_count !== 16'h0) begin
            errors++;
            $display("FAIL flush_reset pc=%h flush=%b sel=%b req=%b cnt=%h want %h 0 00 1 0",
                     pc, flush, pc_sel, imem_req, taken_count, RPC);
        end
        tick();
        tick();
        checks++;
        if (flush !== 1'b0 || imem_req !== 1'b1 || pc !== RPC) begin
            errors++;
            $display("FAIL flush_residue flush=%b req=%b pc=%h want 0 1 %h",
                     flush, imem_req, pc, RPC);
        end
        model_pc = RPC;
    endtask

    task automatic test_taken_count();
        logic [15:0] want;
        decide(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        decide(2'b01, 1'b0, 1'b1, 32'h0000_0900, 32'h0);
        decide(2'b01, 1'b1, 1'b1, 32'h0000_0A00, 32'h0);
        decide(2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_0B00);
        decide(2'b11, 1'b0, 1'b0, 32'h0000_0C00, 32'h0);
`ifdef PC_SEQ_TAKEN_CNT_EN
        want = 16'd3;
`else
        want = 16'd0;
`endif
        checks++;
        if (taken_count !== want) begin
            errors++;
            $display("FAIL taken_count got=%0d want %0d", taken_count, want);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0;
        ctrl_valid = 1'b0;
        bs = 2'b00;
        ps = 1'b0;
        zero = 1'b0;
        bra_target = '0;
        bus_a = '0;
        stall = 1'b0;
        model_pc = RPC;
        test_reset();
        test_seq();
        test_cond();
        test_wrap();
        test_stall_reset();
        test_taken_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
